// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared opcode, ALU, state and control-vector types for the stack-machine controller
package stack_ctrl_pkg;
  localparam int IR_OP_MSB = 7;
  localparam int IR_OP_LSB = 5;
  localparam int IR_OPW = IR_OP_MSB - IR_OP_LSB + 1;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_PUSH, OP_POP, OP_JMP, OP_JZ
  } opcode_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT} alu_op_e;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_POPX, S_POPY, S_EXEC, S_PUSHM, S_POPM
  } state_e;
  typedef struct packed {
    logic    ir_write;
    logic    pc_update;
    logic    pc_write;
    logic    adr_src;
    logic    mem_write;
    logic    stack_src;
    logic    push;
    logic    pop;
    logic    x_write;
    logic    y_write;
    alu_op_e alu_control;
  } ctrl_t;
endpackage

// File: rtl/stack_ctrl_decode.sv
// stack_ctrl_decode: combinational state/opCode/NorTop/stall -> packed control vector (ctrl_t bit order)
module stack_ctrl_decode
  import stack_ctrl_pkg::*;
(
  input  logic [2:0]  state,
  input  logic [2:0]  op_code,
  input  logic        nor_top,
  input  logic        stall,
  output logic [11:0] ctrl
);
  ctrl_t c;
  opcode_e op;
  assign op = opcode_e'(op_code);
  assign ctrl = c;
  always_comb begin
    c = '0;
    c.alu_control = alu_op_e'(op_code[1:0]);
    case (state_e'(state))
      S_FETCH: begin
        c.ir_write = !stall;
        c.pc_update = !stall;
      end
      S_DECODE: c.pc_write = (op == OP_JMP) || (op == OP_JZ && nor_top);
      S_POPX: begin
        c.x_write = 1'b1;
        c.pop = 1'b1;
      end
      S_POPY: begin
        c.y_write = 1'b1;
        c.pop = 1'b1;
      end
      S_EXEC: c.push = 1'b1;
      S_PUSHM: begin
        c.adr_src = 1'b1;
        c.stack_src = 1'b1;
        c.push = 1'b1;
      end
      S_POPM: begin
        c.adr_src = 1'b1;
        c.mem_write = 1'b1;
        c.pop = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/stack_controller.sv
// stack_controller: fetch/decode/execute FSM for the 8-bit stack CPU; PERF_CNT_EN enables the instr_cnt retired-instruction counter
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter int OPW  = IR_OPW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [OPW-1:0]  opCode,
  input  logic            NorTop,
  output logic            IRwrite,
  output logic            PCUpdate,
  output logic            PCwrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            StackSrc,
  output logic            Push,
  output logic            Pop,
  output logic            Xwrite,
  output logic            Ywrite,
  output logic [1:0]      ALUControl,
  output logic            fetch_busy,
  output logic [CNTW-1:0] instr_cnt
);
  state_e state, state_nxt;
  logic [11:0] ctrl;
  always_ff @(posedge clk) state <= rst ? S_FETCH : state_nxt;
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = stall ? S_FETCH : S_DECODE;
      S_DECODE:
        case (opCode)
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_nxt = S_POPX;
          OP_PUSH: state_nxt = S_PUSHM;
          OP_POP: state_nxt = S_POPM;
          default: state_nxt = S_FETCH;
        endcase
      S_POPX: state_nxt = (opCode == OP_NOT) ? S_EXEC : S_POPY;
      S_POPY: state_nxt = S_EXEC;
      default: state_nxt = S_FETCH;
    endcase
  end
  stack_ctrl_decode u_decode (
    .state  (state),
    .op_code(opCode),
    .nor_top(NorTop),
    .stall  (stall),
    .ctrl   (ctrl)
  );
  assign {IRwrite, PCUpdate, PCwrite, AdrSrc, MemWrite, StackSrc, Push, Pop,
          Xwrite, Ywrite, ALUControl} = rst ? 12'd0 : ctrl;
  assign fetch_busy = rst || !(state == S_FETCH && stall);
`ifdef PERF_CNT_EN
  logic [CNTW-1:0] cnt;
  logic retire;
  assign retire = state_nxt == S_FETCH &&
                  (state == S_DECODE || state == S_EXEC || state == S_PUSHM || state == S_POPM);
  always_ff @(posedge clk) cnt <= rst ? '0 : cnt + CNTW'(retire);
  assign instr_cnt = cnt;
`else
  assign instr_cnt = '0;
`endif
  always_ff @(posedge clk)
    if (!rst && state == S_DECODE)
      assert (!$isunknown(opCode)) else $error("stack_controller: unknown opCode in DECODE");
endmodule
